// File: rtl/neo_sdram_arb.sv
// neo_sdram_arb: single-port SDRAM arbiter shared by the 68K, the Z80 and the
// video fetch unit. Only one transfer is outstanding at a time. nDTACK is
// generated here for the 68K zones that are backed by SDRAM.
//
// Handshake rules:
//   SDR_REQ/SDR_ACK: SDR_REQ rises together with stable SDR_ADDR/WE/BE/WDATA.
//   Everything holds until the controller pulses SDR_ACK for one cycle, with
//   SDR_RDATA valid in that cycle. SDR_REQ drops on the same edge that
//   samples SDR_ACK.
//   VID_REQ/Z80_REQ: these are level requests, held until the matching
//   one-cycle *_ACK pulse. A request that is still high at the first edge
//   after the ACK counts as a new request.
//   68K: a request pending while nAS is low is served once. nDTACK falls on
//   the edge after the data is latched and rises on the first edge that
//   samples nAS high.
module neo_sdram_arb #(
  parameter int ADDR_W     = 25,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK_48M,
  input  logic              nRESET,
  input  logic              nAS,
  input  logic              nSDR_SEL,
  input  logic              RW,
  input  logic              nUDS,
  input  logic              nLDS,
  input  logic [ADDR_W-1:0] M68K_WADDR,
  input  logic [15:0]       M68K_WDATA,
  output logic [15:0]       M68K_RDATA,
  output logic              nDTACK,
  input  logic              Z80_REQ,
  input  logic [ADDR_W:0]   Z80_ADDR,
  output logic [7:0]        Z80_RDATA,
  output logic              Z80_ACK,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic [15:0]       VID_RDATA,
  output logic              VID_ACK,
  output logic              SDR_REQ,
  output logic [ADDR_W-1:0] SDR_ADDR,
  output logic              SDR_WE,
  output logic [1:0]        SDR_BE,
  output logic [15:0]       SDR_WDATA,
  input  logic [15:0]       SDR_RDATA,
  input  logic              SDR_ACK,
  output logic              DBG_STATE     // 1 = BUSY, 0 = IDLE
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {G_NONE, G_VID, G_M68K, G_Z80} grant_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  state_t        r_state;
  grant_t        r_grant;
  logic [SW-1:0] r_starve;
  logic          r_m68k_done;
  logic          r_m68k_abort;  // nAS rose while the 68K transfer was in flight
  logic          r_z80_lane;    // Z80 byte lane captured at grant

  logic w_m68k_pend;
  logic w_z80_force;

  // Request qualification for the 68K and the anti-starvation override for the Z80
  always_comb begin
    w_m68k_pend = !nAS && !nSDR_SEL && (!nUDS || !nLDS) && !r_m68k_done;
    w_z80_force = Z80_REQ && (r_starve == STARVE_LIM);
  end

  assign DBG_STATE = (r_state == S_BUSY);

  // Arbitration FSM, SDRAM request registers, completion routing and nDTACK
  always_ff @(posedge CLK_48M) begin
    if (!nRESET) begin
      r_state      <= S_IDLE;
      r_grant      <= G_NONE;
      r_starve     <= '0;
      r_m68k_done  <= 1'b0;
      r_m68k_abort <= 1'b0;
      r_z80_lane   <= 1'b0;
      SDR_REQ      <= 1'b0;
      SDR_ADDR     <= '0;
      SDR_WE       <= 1'b0;
      SDR_BE       <= 2'b00;
      SDR_WDATA    <= 16'h0000;
      M68K_RDATA   <= 16'h0000;
      nDTACK       <= 1'b1;
      Z80_RDATA    <= 8'h00;
      Z80_ACK      <= 1'b0;
      VID_RDATA    <= 16'h0000;
      VID_ACK      <= 1'b0;
    end else begin
      Z80_ACK <= 1'b0;
      VID_ACK <= 1'b0;

      // 68K bus cycle end: release DTACK and re-arm for the next cycle
      if (nAS) begin
        nDTACK      <= 1'b1;
        r_m68k_done <= 1'b0;
      end else if (r_m68k_done) begin
        nDTACK <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_z80_force) begin
            r_grant    <= G_Z80;
            r_z80_lane <= Z80_ADDR[0];
            SDR_ADDR   <= Z80_ADDR[ADDR_W:1];
            SDR_WE     <= 1'b0;
            SDR_BE     <= 2'b11;
            SDR_REQ    <= 1'b1;
            r_state    <= S_BUSY;
          end else if (VID_REQ) begin
            r_grant  <= G_VID;
            SDR_ADDR <= VID_ADDR;
            SDR_WE   <= 1'b0;
            SDR_BE   <= 2'b11;
            SDR_REQ  <= 1'b1;
            r_state  <= S_BUSY;
          end else if (w_m68k_pend) begin
            r_grant      <= G_M68K;
            r_m68k_abort <= 1'b0;
            SDR_ADDR     <= M68K_WADDR;
            SDR_WE       <= !RW;
            SDR_BE       <= {!nUDS, !nLDS};
            SDR_WDATA    <= M68K_WDATA;
            SDR_REQ      <= 1'b1;
            r_state      <= S_BUSY;
          end else if (Z80_REQ) begin
            r_grant    <= G_Z80;
            r_z80_lane <= Z80_ADDR[0];
            SDR_ADDR   <= Z80_ADDR[ADDR_W:1];
            SDR_WE     <= 1'b0;
            SDR_BE     <= 2'b11;
            SDR_REQ    <= 1'b1;
            r_state    <= S_BUSY;
          end

          // Starvation bookkeeping follows the grant chosen above
          if (!Z80_REQ || w_z80_force) begin
            r_starve <= '0;
          end else if (VID_REQ || w_m68k_pend) begin
            if (r_starve != STARVE_LIM) r_starve <= r_starve + SW'(1);
          end else begin
            r_starve <= '0;  // Z80 granted through normal priority
          end
        end

        S_BUSY: begin
          if (!Z80_REQ) r_starve <= '0;

          if (SDR_ACK) begin
            SDR_REQ <= 1'b0;
            r_state <= S_IDLE;
            r_grant <= G_NONE;
            case (r_grant)
              G_VID: begin
                VID_RDATA <= SDR_RDATA;
                VID_ACK   <= 1'b1;
              end
              G_Z80: begin
                Z80_RDATA <= r_z80_lane ? SDR_RDATA[7:0] : SDR_RDATA[15:8];
                Z80_ACK   <= 1'b1;
              end
              G_M68K: begin
                // Data is only delivered if the same bus cycle is still active
                if (!nAS && !r_m68k_abort) begin
                  M68K_RDATA  <= SDR_RDATA;
                  r_m68k_done <= 1'b1;
                end
                r_m68k_abort <= 1'b0;
              end
              default: ;
            endcase
          end else if (nAS && (r_grant == G_M68K)) begin
            r_m68k_abort <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_sdram_arb.sv
// Directed bench for neo_sdram_arb: reset, 68K read/write, Z80 starvation
// override, aborted 68K cycles and reset while a transfer is in flight.
module tb_neo_sdram_arb;

  localparam int ADDR_W = 25;

  logic              clk = 1'b0;
  logic              nRESET;
  logic              nAS, nSDR_SEL, RW, nUDS, nLDS;
  logic [ADDR_W-1:0] M68K_WADDR;
  logic [15:0]       M68K_WDATA, M68K_RDATA;
  logic              nDTACK;
  logic              Z80_REQ;
  logic [ADDR_W:0]   Z80_ADDR;
  logic [7:0]        Z80_RDATA;
  logic              Z80_ACK;
  logic              VID_REQ;
  logic [ADDR_W-1:0] VID_ADDR;
  logic [15:0]       VID_RDATA;
  logic              VID_ACK;
  logic              SDR_REQ;
  logic [ADDR_W-1:0] SDR_ADDR;
  logic              SDR_WE;
  logic [1:0]        SDR_BE;
  logic [15:0]       SDR_WDATA, SDR_RDATA;
  logic              SDR_ACK;
  logic              DBG_STATE;

  int n_tests = 0;
  int n_fail  = 0;

  neo_sdram_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .CLK_48M(clk), .nRESET(nRESET), .nAS(nAS), .nSDR_SEL(nSDR_SEL), .RW(RW),
    .nUDS(nUDS), .nLDS(nLDS), .M68K_WADDR(M68K_WADDR), .M68K_WDATA(M68K_WDATA),
    .M68K_RDATA(M68K_RDATA), .nDTACK(nDTACK), .Z80_REQ(Z80_REQ), .Z80_ADDR(Z80_ADDR),
    .Z80_RDATA(Z80_RDATA), .Z80_ACK(Z80_ACK), .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR),
    .VID_RDATA(VID_RDATA), .VID_ACK(VID_ACK), .SDR_REQ(SDR_REQ), .SDR_ADDR(SDR_ADDR),
    .SDR_WE(SDR_WE), .SDR_BE(SDR_BE), .SDR_WDATA(SDR_WDATA), .SDR_RDATA(SDR_RDATA),
    .SDR_ACK(SDR_ACK), .DBG_STATE(DBG_STATE)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Test 1: reset held with every requester active
    nRESET = 1'b0; nAS = 1'b1; nSDR_SEL = 1'b1; RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    M68K_WADDR = '0; M68K_WDATA = 16'h0; Z80_REQ = 1'b1; Z80_ADDR = 26'h0000601;
    VID_REQ = 1'b1; VID_ADDR = 25'h0ABCDE; SDR_RDATA = 16'h0; SDR_ACK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t1_reset_outs", {28'h0, SDR_REQ, nDTACK, Z80_ACK, VID_ACK}, 32'h4);
    end
    check("t1_reset_data", {M68K_RDATA, VID_RDATA}, 32'h0);
    nRESET = 1'b1;
    cyc();
    check("t1_vid_first", {6'h0, SDR_REQ, SDR_WE, SDR_BE, SDR_ADDR}, {6'h0, 1'b1, 1'b0, 2'b11, 25'h0ABCDE});
    SDR_ACK = 1'b1; SDR_RDATA = 16'h1234;
    cyc();
    SDR_ACK = 1'b0; VID_REQ = 1'b0; Z80_REQ = 1'b0;
    check("t1_vid_ack", {14'h0, VID_ACK, SDR_REQ, VID_RDATA}, {14'h0, 1'b1, 1'b0, 16'h1234});
    cyc();
    check("t1_idle", {29'h0, SDR_REQ, VID_ACK, DBG_STATE}, 32'h0);

    // Test 2: 68K word read at 0x000100
    nAS = 1'b0; nSDR_SEL = 1'b0; RW = 1'b1; nUDS = 1'b0; nLDS = 1'b0; M68K_WADDR = 25'h000100;
    cyc();
    check("t2_grant", {6'h0, SDR_REQ, SDR_WE, SDR_BE, SDR_ADDR}, {6'h0, 1'b1, 1'b0, 2'b11, 25'h000100});
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2_wait", {30'h0, SDR_REQ, nDTACK}, 32'h3);
    end
    SDR_ACK = 1'b1; SDR_RDATA = 16'hBEEF;
    cyc();
    SDR_ACK = 1'b0;
    check("t2_ack_edge", {14'h0, SDR_REQ, nDTACK, M68K_RDATA}, {14'h0, 1'b0, 1'b1, 16'hBEEF});
    cyc();
    check("t2_dtack_low", {15'h0, nDTACK, M68K_RDATA}, {15'h0, 1'b0, 16'hBEEF});
    cyc();
    check("t2_no_regrant", {30'h0, SDR_REQ, nDTACK}, 32'h0);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    cyc();
    check("t2_dtack_high", {30'h0, SDR_REQ, nDTACK}, 32'h1);

    // Test 3: 68K lower-byte write
    nAS = 1'b0; RW = 1'b0; nUDS = 1'b1; nLDS = 1'b0; M68K_WADDR = 25'h000200; M68K_WDATA = 16'h0012;
    cyc();
    check("t3_grant", {2'h0, SDR_REQ, SDR_WE, SDR_BE, SDR_ADDR[9:0], SDR_WDATA},
          {2'h0, 1'b1, 1'b1, 2'b01, 10'h200, 16'h0012});
    cyc();
    SDR_ACK = 1'b1; SDR_RDATA = 16'h0;
    cyc();
    SDR_ACK = 1'b0;
    cyc();
    check("t3_dtack_low", {31'h0, nDTACK}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t3_single_req", {30'h0, SDR_REQ, DBG_STATE}, 32'h0);
    end
    nAS = 1'b1; nLDS = 1'b1; RW = 1'b1;
    cyc();
    check("t3_dtack_high", {31'h0, nDTACK}, 32'h1);

    // Test 4: Z80 forced through after four lost arbitrations
    VID_REQ = 1'b1; VID_ADDR = 25'h0001C0; Z80_REQ = 1'b1; Z80_ADDR = 26'h0000601;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t4_vid_wins", {6'h0, SDR_REQ, SDR_BE, SDR_ADDR}, {6'h0, 1'b1, 2'b11, 25'h0001C0});
      SDR_ACK = 1'b1; SDR_RDATA = 16'h1000 + 16'(i);
      cyc();
      SDR_ACK = 1'b0;
      check("t4_vid_ack", {15'h0, VID_ACK, VID_RDATA}, {15'h0, 1'b1, 16'h1000 + 16'(i)});
    end
    cyc();
    check("t4_z80_forced", {6'h0, SDR_REQ, SDR_WE, SDR_BE, SDR_ADDR}, {6'h0, 1'b1, 1'b0, 2'b11, 25'h000300});
    SDR_ACK = 1'b1; SDR_RDATA = 16'hA55A;
    cyc();
    SDR_ACK = 1'b0; VID_REQ = 1'b0; Z80_REQ = 1'b0;
    check("t4_z80_low_byte", {22'h0, Z80_ACK, VID_ACK, Z80_RDATA}, {22'h0, 1'b1, 1'b0, 8'h5A});
    cyc();
    check("t4_idle", {30'h0, SDR_REQ, Z80_ACK}, 32'h0);
    Z80_REQ = 1'b1; Z80_ADDR = 26'h0000800;
    cyc();
    check("t4_z80_grant", {6'h0, SDR_REQ, SDR_ADDR}, {6'h0, 1'b1, 25'h000400});
    SDR_ACK = 1'b1; SDR_RDATA = 16'hA55A;
    cyc();
    SDR_ACK = 1'b0; Z80_REQ = 1'b0;
    check("t4_z80_high_byte", {23'h0, Z80_ACK, Z80_RDATA}, {23'h0, 1'b1, 8'hA5});
    cyc();

    // Test 5: 68K cycle abandoned before completion, then served normally
    nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0; RW = 1'b1; M68K_WADDR = 25'h000400;
    cyc();
    check("t5_grant", {6'h0, SDR_REQ, SDR_ADDR}, {6'h0, 1'b1, 25'h000400});
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    cyc();
    cyc();
    SDR_ACK = 1'b1; SDR_RDATA = 16'hDEAD;
    cyc();
    SDR_ACK = 1'b0;
    check("t5_discard", {14'h0, SDR_REQ, nDTACK, M68K_RDATA}, {14'h0, 1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("t5_dtack_stays_high", {30'h0, SDR_REQ, nDTACK}, 32'h1);
    end
    nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0; M68K_WADDR = 25'h000500;
    cyc();
    check("t5_next_grant", {6'h0, SDR_REQ, SDR_ADDR}, {6'h0, 1'b1, 25'h000500});
    SDR_ACK = 1'b1; SDR_RDATA = 16'h7777;
    cyc();
    SDR_ACK = 1'b0;
    cyc();
    check("t5_next_read", {15'h0, nDTACK, M68K_RDATA}, {15'h0, 1'b0, 16'h7777});
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    cyc();
    // nAS rising on the same edge that samples SDR_ACK
    nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0; M68K_WADDR = 25'h000600;
    cyc();
    check("t5_race_grant", {6'h0, SDR_REQ, SDR_ADDR}, {6'h0, 1'b1, 25'h000600});
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; SDR_ACK = 1'b1; SDR_RDATA = 16'h4321;
    cyc();
    SDR_ACK = 1'b0;
    check("t5_race_discard", {15'h0, nDTACK, M68K_RDATA}, {15'h0, 1'b1, 16'h7777});
    cyc();
    check("t5_race_dtack", {30'h0, SDR_REQ, nDTACK}, 32'h1);

    // Test 6: reset while a transfer is in flight
    VID_REQ = 1'b1; VID_ADDR = 25'h000777;
    cyc();
    check("t6_busy", {30'h0, SDR_REQ, DBG_STATE}, 32'h3);
    nRESET = 1'b0;
    cyc();
    check("t6_reset_drop", {28'h0, SDR_REQ, DBG_STATE, VID_ACK, Z80_ACK}, 32'h0);
    cyc();
    check("t6_reset_hold", {30'h0, SDR_REQ, VID_ACK}, 32'h0);
    nRESET = 1'b1; VID_REQ = 1'b0;
    cyc();
    check("t6_idle_after", {29'h0, SDR_REQ, DBG_STATE, VID_ACK}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
